// File: rtl/msg_sched_seq_if.sv
// ALU instruction encodings and the bus bundle connecting msg_sched_seq
// to its load source, the shared ALU and the schedule-word consumer.
package msg_sched_pkg;
  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
  } instruction_s;

  localparam instruction_s kNOP  = '{opcode: 6'h00, funct: 6'h00};
  localparam instruction_s kADDU = '{opcode: 6'h00, funct: 6'h21};
  localparam instruction_s kLA   = '{opcode: 6'h1c, funct: 6'h30};  // sigma0(rs)
  localparam instruction_s kLB   = '{opcode: 6'h1c, funct: 6'h31};  // sigma1(rs)
endpackage

interface msg_sched_seq_if;
  import msg_sched_pkg::*;

  logic         start_i;
  logic         load_valid_i;
  logic [31:0]  load_data_i;
  instruction_s alu_op_o;
  logic [31:0]  alu_rd_o;
  logic [31:0]  alu_rs_o;
  logic [31:0]  alu_result_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_data_o;
  logic [5:0]   out_index_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, load_valid_i, load_data_i, alu_result_i, out_ready_i,
    input  alu_op_o, alu_rd_o, alu_rs_o, out_valid_o, out_data_o, out_index_o,
           busy_o, done_o
  );

  modport slave (
    input  start_i, load_valid_i, load_data_i, alu_result_i, out_ready_i,
    output alu_op_o, alu_rd_o, alu_rs_o, out_valid_o, out_data_o, out_index_o,
           busy_o, done_o
  );
endinterface

// File: rtl/msg_sched_seq.sv
// SHA-256 message schedule sequencer: loads W[0..15], then computes W[16..63]
// one word at a time through a shared external ALU, five ALU ops per word.
module msg_sched_seq
  import msg_sched_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  msg_sched_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, S0, S1, S2, S3, S4, OUT} state_e;

  state_e       r_state;
  state_e       w_next;
  logic [3:0]   r_cnt;
  logic [5:0]   r_t;
  logic         r_done;
  logic [31:0]  r_sb;
  logic [31:0]  r_sa;
  logic [31:0]  r_acc;
  logic [31:0]  r_buf [16];

  logic [3:0]   w_t4;
  logic [3:0]   w_i2;
  logic [3:0]   w_i7;
  logic [3:0]   w_i15;
  logic         w_load;
  logic         w_xfer;
  instruction_s w_op;
  logic [31:0]  w_rd;
  logic [31:0]  w_rs;

  // Circular buffer: W[t-k] lives in slot (t-k) mod 16, and W[t-16] shares t's slot.
  assign w_t4   = r_t[3:0];
  assign w_i2   = w_t4 + 4'd14;
  assign w_i7   = w_t4 + 4'd9;
  assign w_i15  = w_t4 + 4'd1;
  assign w_load = (r_state == LOAD) && bus.load_valid_i;
  assign w_xfer = (r_state == OUT) && bus.out_ready_i;

  always_comb begin
    w_next = r_state;
    w_op   = kNOP;
    w_rd   = '0;
    w_rs   = '0;
    case (r_state)
      IDLE: if (bus.start_i) w_next = LOAD;
      LOAD: if (w_load && r_cnt == 4'd15) w_next = S0;
      S0: begin
        w_op   = kLB;
        w_rs   = r_buf[w_i2];
        w_next = S1;
      end
      S1: begin
        w_op   = kLA;
        w_rs   = r_buf[w_i15];
        w_next = S2;
      end
      S2: begin
        w_op   = kADDU;
        w_rd   = r_sb;
        w_rs   = r_buf[w_i7];
        w_next = S3;
      end
      S3: begin
        w_op   = kADDU;
        w_rd   = r_acc;
        w_rs   = r_sa;
        w_next = S4;
      end
      S4: begin
        w_op   = kADDU;
        w_rd   = r_acc;
        w_rs   = r_buf[w_t4];
        w_next = OUT;
      end
      OUT: if (w_xfer) w_next = (r_t == 6'd63) ? IDLE : S0;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_t     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_xfer && (r_t == 6'd63);
      if (r_state == IDLE && bus.start_i) r_cnt <= '0;
      if (w_load) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) r_t <= 6'd16;
      end
      if (w_xfer) r_t <= r_t + 6'd1;
    end
  end

  // Datapath registers carry no reset; their contents are only observed
  // once the control state has walked through the states that write them.
  always_ff @(posedge clk) begin
    case (r_state)
      S0:         r_sb  <= bus.alu_result_i;
      S1:         r_sa  <= bus.alu_result_i;
      S2, S3, S4: r_acc <= bus.alu_result_i;
      default: ;
    endcase
    if (!reset) begin
      if (w_load) r_buf[r_cnt] <= bus.load_data_i;
      if (w_xfer) r_buf[w_t4]  <= r_acc;
    end
  end

  assign bus.alu_op_o    = w_op;
  assign bus.alu_rd_o    = w_rd;
  assign bus.alu_rs_o    = w_rs;
  assign bus.out_valid_o = (r_state == OUT);
  assign bus.out_data_o  = (r_state == OUT) ? r_acc : '0;
  assign bus.out_index_o = (r_state == OUT) ? r_t : '0;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = r_done;
endmodule

// File: tb/tb_msg_sched_seq.sv
// Bench for msg_sched_seq: models the shared ALU, checks per-state ALU traffic
// from a table, then full schedules against a SHA-256 reference.
module tb_msg_sched_seq;
  import msg_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  msg_sched_seq_if ifc ();
  msg_sched_seq dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] msg   [16];
  logic [31:0] ref_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Shared ALU: combinational result for whatever op the DUT presents.
  always_comb begin
    if (ifc.alu_op_o == kLB)        ifc.alu_result_i = sig1(ifc.alu_rs_o);
    else if (ifc.alu_op_o == kLA)   ifc.alu_result_i = sig0(ifc.alu_rs_o);
    else if (ifc.alu_op_o == kADDU) ifc.alu_result_i = ifc.alu_rd_o + ifc.alu_rs_o;
    else                            ifc.alu_result_i = 32'h0;
  end

  task automatic build_ref();
    for (int i = 0; i < 16; i++) ref_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      ref_w[i] = sig1(ref_w[i-2]) + ref_w[i-7] + sig0(ref_w[i-15]) + ref_w[i-16];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.start_i      = 1'b0;
    ifc.load_valid_i = 1'b0;
    ifc.load_data_i  = 32'h0;
    ifc.out_ready_i  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op"},    {20'd0, ifc.alu_op_o}, 32'h0);
    chk({tag, "_rd"},    ifc.alu_rd_o, 32'h0);
    chk({tag, "_rs"},    ifc.alu_rs_o, 32'h0);
    chk({tag, "_valid"}, {31'd0, ifc.out_valid_o}, 32'h0);
    chk({tag, "_data"},  ifc.out_data_o, 32'h0);
    chk({tag, "_index"}, {26'd0, ifc.out_index_o}, 32'h0);
    chk({tag, "_busy"},  {31'd0, ifc.busy_o}, 32'h0);
    chk({tag, "_done"},  {31'd0, ifc.done_o}, 32'h0);
  endtask

  task automatic load_msg(input bit gaps);
    ifc.start_i = 1'b1;
    step();
    ifc.start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        repeat (g) begin
          ifc.load_valid_i = 1'b0;
          ifc.load_data_i  = $urandom;
          step();
        end
      end
      ifc.load_valid_i = 1'b1;
      ifc.load_data_i  = msg[i];
      step();
    end
    ifc.load_valid_i = 1'b0;
  endtask

  // Called while the DUT sits in S0 of W[16]. Optionally stalls the consumer for
  // 20 cycles on one word, injects start/load noise, or resets at S2 of a word.
  task automatic drain(input int stall_idx, input bit noise, input int abort_idx);
    int cyc = 0, nxt = 16, stall = 0, first_v = -1;
    bit seen_done = 0;
    logic [31:0] hold_d = '0;
    logic [5:0]  hold_i = '0;
    instruction_s prev_op = kNOP;
    while (cyc < 1000 && !seen_done) begin
      if (abort_idx > 0 && nxt == abort_idx && ifc.alu_op_o == kADDU && prev_op == kLA) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("reset_at_s2");
        return;
      end
      prev_op = ifc.alu_op_o;
      if (ifc.out_valid_o && first_v < 0) first_v = cyc;
      ifc.out_ready_i = 1'b1;
      if (ifc.out_valid_o && int'(ifc.out_index_o) == stall_idx) begin
        if (stall == 0) begin
          hold_d = ifc.out_data_o;
          hold_i = ifc.out_index_o;
        end else begin
          chk("stall_data", ifc.out_data_o, hold_d);
          chk("stall_index", {26'd0, ifc.out_index_o}, {26'd0, hold_i});
          chk("stall_op_nop", {20'd0, ifc.alu_op_o}, 32'h0);
          chk("stall_rs_zero", ifc.alu_rs_o, 32'h0);
        end
        if (stall < 20) begin
          ifc.out_ready_i = 1'b0;
          stall++;
        end
      end
      if (ifc.out_valid_o && ifc.out_ready_i) begin
        chk($sformatf("W[%0d]", nxt), ifc.out_data_o, ref_w[ifc.out_index_o]);
        chk("out_index", {26'd0, ifc.out_index_o}, 32'(nxt));
        nxt++;
      end
      if (noise) begin
        ifc.start_i      = 1'($urandom_range(0, 1));
        ifc.load_valid_i = 1'($urandom_range(0, 1));
        ifc.load_data_i  = $urandom;
      end
      step();
      cyc++;
      if (ifc.done_o) seen_done = 1;
    end
    clear_inputs();
    if (!seen_done) begin
      n_chk++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", cyc);
    end else begin
      chk("words_out", 32'(nxt), 32'd64);
      chk("cycles_to_done", 32'(cyc), (stall_idx >= 16) ? 32'd308 : 32'd288);
      chk("first_valid_latency", 32'(first_v), 32'd5);
      chk("idle_after_done", {31'd0, ifc.busy_o}, 32'h0);
      step();
      chk("done_one_cycle", {31'd0, ifc.done_o}, 32'h0);
    end
  endtask

  typedef struct {
    string        name;
    logic         rdy, st, lv;
    instruction_s op;
    logic [31:0]  rd, rs;
    logic         vld;
    logic [31:0]  data;
    logic [5:0]   idx;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rdy, input logic st, input logic lv,
                              input instruction_s op, input logic [31:0] rd, input logic [31:0] rs,
                              input logic vld, input logic [31:0] data, input logic [5:0] idx);
    vec_t v;
    v.name = name; v.rdy = rdy; v.st = st; v.lv = lv; v.op = op;
    v.rd = rd; v.rs = rs; v.vld = vld; v.data = data; v.idx = idx;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    // Expected ALU traffic for W[16] and W[17] of the "abc" block, by hand.
    tbl[0]  = mk("w16_s0",  1, 1, 1, kLB,   32'h0,     32'h0,        0, 32'h0,        6'd0);
    tbl[1]  = mk("w16_s1",  0, 0, 1, kLA,   32'h0,     32'h0,        0, 32'h0,        6'd0);
    tbl[2]  = mk("w16_s2",  1, 1, 0, kADDU, 32'h0,     32'h0,        0, 32'h0,        6'd0);
    tbl[3]  = mk("w16_s3",  0, 0, 0, kADDU, 32'h0,     32'h0,        0, 32'h0,        6'd0);
    tbl[4]  = mk("w16_s4",  1, 0, 0, kADDU, 32'h0,     32'h61626380, 0, 32'h0,        6'd0);
    tbl[5]  = mk("w16_out", 0, 1, 1, kNOP,  32'h0,     32'h0,        1, 32'h61626380, 6'd16);
    tbl[6]  = mk("w16_hld", 1, 0, 0, kNOP,  32'h0,     32'h0,        1, 32'h61626380, 6'd16);
    tbl[7]  = mk("w17_s0",  1, 0, 0, kLB,   32'h0,     32'h00000018, 0, 32'h0,        6'd0);
    tbl[8]  = mk("w17_s1",  1, 0, 1, kLA,   32'h0,     32'h0,        0, 32'h0,        6'd0);
    tbl[9]  = mk("w17_s2",  1, 0, 0, kADDU, 32'h000F0000, 32'h0,     0, 32'h0,        6'd0);
    tbl[10] = mk("w17_s3",  1, 1, 0, kADDU, 32'h000F0000, 32'h0,     0, 32'h0,        6'd0);
    tbl[11] = mk("w17_s4",  1, 0, 0, kADDU, 32'h000F0000, 32'h0,     0, 32'h0,        6'd0);
    tbl[12] = mk("w17_out", 1, 1, 0, kNOP,  32'h0,     32'h0,        1, 32'h000F0000, 6'd17);
    tbl[13] = mk("w18_s0",  1, 0, 0, kLB,   32'h0,     32'h61626380, 0, 32'h0,        6'd0);

    clear_inputs();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_reset_outputs("post_reset");
    end
    ifc.load_valid_i = 1'b1;
    ifc.load_data_i  = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("load_valid_in_idle", {31'd0, ifc.busy_o}, 32'h0);
    clear_inputs();

    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_ref();

    // Per-state walk through the first two words, with start/load noise.
    load_msg(0);
    for (int i = 0; i < 14; i++) begin
      chk({tbl[i].name, "_op"},    {20'd0, ifc.alu_op_o}, {20'd0, tbl[i].op});
      chk({tbl[i].name, "_rd"},    ifc.alu_rd_o, tbl[i].rd);
      chk({tbl[i].name, "_rs"},    ifc.alu_rs_o, tbl[i].rs);
      chk({tbl[i].name, "_valid"}, {31'd0, ifc.out_valid_o}, {31'd0, tbl[i].vld});
      chk({tbl[i].name, "_data"},  ifc.out_data_o, tbl[i].data);
      chk({tbl[i].name, "_index"}, {26'd0, ifc.out_index_o}, {26'd0, tbl[i].idx});
      chk({tbl[i].name, "_busy"},  {31'd0, ifc.busy_o}, 32'h1);
      ifc.out_ready_i  = tbl[i].rdy;
      ifc.start_i      = tbl[i].st;
      ifc.load_valid_i = tbl[i].lv;
      ifc.load_data_i  = 32'hA5A5_A5A5;
      step();
    end
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("reset_mid_compute");

    // Reset mid-LOAD must discard the partial load.
    ifc.start_i = 1'b1;
    step();
    ifc.start_i = 1'b0;
    chk("busy_in_load", {31'd0, ifc.busy_o}, 32'h1);
    ifc.load_valid_i = 1'b1;
    ifc.load_data_i  = 32'h1234_5678;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_inputs();
    check_reset_outputs("reset_mid_load");

    load_msg(0);
    drain(-1, 0, 0);

    load_msg(0);
    drain(20, 1, 0);

    load_msg(0);
    drain(-1, 0, 30);
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_ref();
    load_msg(0);
    drain(-1, 0, 0);

    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_ref();
    load_msg(1);
    drain(-1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/msg_sched_seq.md
MSG_SCHED_SEQ -- requirements
Module: msg_sched_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), one clock, synchronous active-high reset:
- clk  in  1  core clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin a new 64-word schedule
- load_valid_i  in  1  load_data_i holds the next message word W[0..15]
- load_data_i  in  32  message word, W[0] first
- alu_op_o  out  instruction_s  op driven to the shared ALU (kLB, kLA, kADDU patterns from the definitions package; all-zero = NOP)
- alu_rd_o  out  32  ALU rd operand
- alu_rs_o  out  32  ALU rs operand
- alu_result_i  in  32  ALU result (combinational, same cycle)
- out_valid_o  out  1  out_data_o holds a computed schedule word
- out_ready_i  in  1  consumer accepts the word this cycle
- out_data_o  out  32  schedule word W[t]
- out_index_o  out  6  t, 16..63
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after W[63] is accepted
REQ-002 The block SHALL ignore the ALU jump output; the block has no parameters.

Function
REQ-003 States SHALL be IDLE, LOAD, S0, S1, S2, S3, S4, OUT.
REQ-004 IDLE: start_i=1 -> LOAD, load counter cleared; otherwise the block stays in IDLE.
REQ-005 LOAD: each cycle with load_valid_i=1 writes load_data_i to buffer slot [count] and increments count; the cycle that accepts the 16th word -> S0 with t=16.
REQ-006 The buffer SHALL be a 16x32 circular store; W[k] lives in slot k mod 16.
REQ-007 S0: op=kLB, rs=W[t-2], rd=0; capture result as sb.
REQ-008 S1: op=kLA, rs=W[t-15], rd=0; capture result as sa.
REQ-009 S2: op=kADDU, rd=sb, rs=W[t-7]; capture result as acc.
REQ-010 S3: op=kADDU, rd=acc, rs=sa; capture result as acc.
REQ-011 S4: op=kADDU, rd=acc, rs=W[t-16]; capture result as acc -> OUT.
REQ-012 All additions SHALL wrap modulo 2^32.
REQ-013 OUT: out_valid_o=1, out_data_o=acc, out_index_o=t; ALU port driven to NOP with zero operands.
REQ-014 OUT handshake: transfer occurs only when out_valid_o and out_ready_i are both high. Until transfer, out_data_o and out_index_o SHALL hold stable.
REQ-015 On transfer, acc SHALL be written to slot t mod 16 (overwriting W[t-16]) and t SHALL increment.
REQ-016 After a transfer with t<63 the next state SHALL be S0; with t=63 it SHALL be IDLE, with done_o=1 for exactly the next cycle.
REQ-017 Latency: out_valid_o rises 6 cycles after the 16th load cycle. With out_ready_i held high, each word takes 6 cycles; all 48 words take 288 cycles.
REQ-018 Outside S0-S4 the ALU port SHALL be NOP with alu_rd_o=alu_rs_o=0.
REQ-019 start_i SHALL be ignored in every state except IDLE.
REQ-020 load_valid_i SHALL be ignored outside LOAD. LOAD waits indefinitely; gaps between words are allowed.
REQ-021 out_valid_o SHALL be low in every state except OUT.

Reset
REQ-022 reset=1 SHALL force IDLE on the next edge from any state, including mid-LOAD and mid-compute, and SHALL discard any partial schedule.
REQ-023 Reset values SHALL be:
- out_valid_o=0, out_data_o=0, out_index_o=0, busy_o=0, done_o=0
- alu_op_o=NOP, alu_rd_o=0, alu_rs_o=0
- load count=0, t=0
REQ-024 Buffer contents SHALL NOT require reset.
REQ-025 reset SHALL take priority over start_i, load_valid_i and out_ready_i.

Verification
REQ-026 Apply reset, then release with all inputs low -> all outputs 0, busy_o=0, for at least 10 cycles.
REQ-027 Load the "abc" block (W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018) with out_ready_i=1 -> W[16]=0x61626380 (index 16), W[17]=0x000F0000 (index 17); all 48 words match a reference SHA-256 model; done_o pulses once 288 cycles after the first S0.
REQ-028 Hold out_ready_i=0 for 20 cycles while out_valid_o is high -> out_data_o and out_index_o stay stable, no word is lost or duplicated, the ALU stays at NOP.
REQ-029 Pulse start_i and load_valid_i during compute -> no effect on the sequence or the results.
REQ-030 Assert reset during S2 of word 30 -> IDLE next cycle, outputs at reset values; a fresh start then produces the correct full schedule.
REQ-031 Load with random gaps in load_valid_i -> W[16] appears 6 cycles after the 16th accepted word.
